// File: rtl/controlador_envase_pkg.sv
// Shared definitions for the bottling-line sequencer.
// Holds the state encoding (also driven out on the state port) and a
// helper that sizes the down-counters used to time the valve and capper.
package controlador_envase_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MOVE  = 3'd1,
    FILL  = 3'd2,
    CAP   = 3'd3,
    ALARM = 3'd4
  } state_t;

  // Bits needed to hold the values 0..n.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_borda.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk      system clock
//   reset    synchronous, active-high; clears all three flops
//   din      asynchronous input level
//   edge_out one-cycle pulse per rising edge of din (sync2 & ~hist)
// A sample taken high at edge k yields edge_out high between edges k+1
// and k+2.
module sync_borda (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic edge_out
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_out = sync2 & ~hist;

endmodule

// File: rtl/controlador_envase.sv
// Bottling-line sequencer fed by the frequency divider's slow clock.
// The divided clock is sampled as data; each rising edge becomes a
// one-cycle tick that times the fill valve and the capper.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   tick_src        divided clock (asynchronous data)
//   start, stop     operator level controls
//   bottle_sensor   bottle-under-nozzle sensor (asynchronous)
//   tank_low        reservoir-low flag (synchronous to clk)
//   motor, valve, capper, alarm   Moore actuator outputs
//   batch_done      one-cycle pulse when a batch completes
//   bottle_count    bottles completed in the current batch
//   state           current state encoding
module controlador_envase
  import controlador_envase_pkg::*;
#(
  parameter int unsigned FILL_TICKS = 5,
  parameter int unsigned CAP_TICKS  = 3,
  parameter int unsigned BATCH_SIZE = 12,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_src,
  input  logic             start,
  input  logic             stop,
  input  logic             bottle_sensor,
  input  logic             tank_low,
  output logic             motor,
  output logic             valve,
  output logic             capper,
  output logic             alarm,
  output logic             batch_done,
  output logic [CNT_W-1:0] bottle_count,
  output logic [2:0]       state
);

  localparam int unsigned FILL_W = cnt_bits(FILL_TICKS);
  localparam int unsigned CAP_W  = cnt_bits(CAP_TICKS);

  logic tick;
  logic bottle_edge;

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CAP_W-1:0]    cap_q, cap_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                done_q, done_d;

  sync_borda u_sync_tick (
    .clk      (clk),
    .reset    (reset),
    .din      (tick_src),
    .edge_out (tick)
  );

  sync_borda u_sync_sensor (
    .clk      (clk),
    .reset    (reset),
    .din      (bottle_sensor),
    .edge_out (bottle_edge)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fill_q  <= '0;
      cap_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cap_q   <= cap_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Priority inside each active state: stop, then tank_low, then ticks.
  // The FILL load happens on the MOVE->FILL edge, so a tick in that same
  // cycle is seen while still in MOVE and is not counted.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cap_d   = cap_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) state_d = tank_low ? ALARM : MOVE;
      end
      MOVE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tank_low) begin
          state_d = ALARM;
        end else if (bottle_edge) begin
          state_d = FILL;
          fill_d  = FILL_W'(FILL_TICKS);
        end
      end
      FILL: begin
        if (stop) begin
          state_d = IDLE;
          fill_d  = '0;
        end else if (tank_low) begin
          state_d = ALARM;
          fill_d  = '0;
        end else if (tick) begin
          if (fill_q == FILL_W'(1)) begin
            state_d = CAP;
            fill_d  = '0;
            cap_d   = CAP_W'(CAP_TICKS);
          end else begin
            fill_d = fill_q - FILL_W'(1);
          end
        end
      end
      CAP: begin
        // tank_low is deliberately ignored so the capping cycle completes.
        if (stop) begin
          state_d = IDLE;
          cap_d   = '0;
        end else if (tick) begin
          if (cap_q == CAP_W'(1)) begin
            cap_d = '0;
            if (count_q == CNT_W'(BATCH_SIZE - 1)) begin
              count_d = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              count_d = count_q + CNT_W'(1);
              state_d = MOVE;
            end
          end else begin
            cap_d = cap_q - CAP_W'(1);
          end
        end
      end
      ALARM: begin
        if (start && !tank_low) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        fill_d  = '0;
        cap_d   = '0;
      end
    endcase
  end

  assign motor        = (state_q == MOVE);
  assign valve        = (state_q == FILL);
  assign capper       = (state_q == CAP);
  assign alarm        = (state_q == ALARM);
  assign batch_done   = done_q;
  assign bottle_count = count_q;
  assign state        = state_q;

endmodule

// File: doc/controlador_envase.md
Name: controlador_envase

Overview:
- Bottling-line sequencer directly downstream of the frequency divider.
- Samples the divider's slow clock output as a data signal and converts each rising edge into a one-cycle tick.
- Uses these ticks to time the fill valve and the capper.
- Drives the conveyor, valve, capper and alarm; counts bottles per batch.

Parameters:
FILL_TICKS, 5, ticks the fill valve stays open per bottle (>=1)
CAP_TICKS, 3, ticks the capper stays active per bottle (>=1)
BATCH_SIZE, 12, bottles per batch (1 .. 2^CNT_W-1)
CNT_W, 8, width of bottle counter

Ports:
clk  in  1  system clock, the same clock that feeds the divider
reset  in  1  synchronous, active-high reset
tick_src  in  1  divided clock from the divider, treated as asynchronous data
start  in  1  operator start, level
stop  in  1  operator stop, level
bottle_sensor  in  1  bottle-under-nozzle sensor, asynchronous
tank_low  in  1  reservoir-low flag, already synchronous to clk
motor  out  1  conveyor enable
valve  out  1  fill valve open
capper  out  1  capper active
alarm  out  1  reservoir alarm
batch_done  out  1  one-cycle pulse when a batch completes
bottle_count  out  CNT_W  bottles completed in the current batch
state  out  3  current state encoding

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. Reset has priority over everything.
- Reset values: state=IDLE, motor=valve=capper=alarm=batch_done=0, bottle_count=0, all counters and synchronizer flops=0.
- Tick generation: tick_src passes through 2 flops plus one history flop; tick = sync2 & ~hist.
  - If tick_src is sampled high at edge k, tick is high for the single cycle between edges k+1 and k+2.
  - Exactly one tick per tick_src rising edge. No tick on falling edges.
- Sensor edge: bottle_sensor uses an identical synchronizer/edge detector, giving bottle_edge (one cycle, rising edge only).
- Outputs: motor, valve, capper and alarm are Moore outputs decoded from the registered state. They change on the same edge as the state.
- States and transitions (priority: reset > stop > tank_low > normal):
  - IDLE: all actuators off.
    - start & !tank_low -> MOVE.
    - start & tank_low -> ALARM.
  - MOVE: motor=1.
    - bottle_edge -> FILL, with fill_cnt loaded to FILL_TICKS.
    - A sensor already high on entry is ignored; only a new rising edge counts.
  - FILL: valve=1, motor=0.
    - Each tick decrements fill_cnt.
    - Tick with fill_cnt==1 -> CAP, with cap_cnt loaded to CAP_TICKS.
    - FILL therefore lasts exactly FILL_TICKS ticks.
  - CAP: capper=1. Each tick decrements cap_cnt. On a tick with cap_cnt==1:
    - If bottle_count==BATCH_SIZE-1: bottle_count<=0, batch_done=1 for that one cycle, -> IDLE.
    - Else: bottle_count+1, -> MOVE.
  - ALARM: alarm=1, all other actuators 0.
    - start & !tank_low -> IDLE.
    - stop has no effect here.
- stop: in MOVE/FILL/CAP -> IDLE on the next edge. Actuators drop with the state change. bottle_count is preserved and fill/cap counters are discarded.
- tank_low: in MOVE or FILL -> ALARM on the next edge, so the valve closes within 1 cycle. In CAP the capping cycle completes first.
- Simultaneous events:
  - stop and tank_low together: stop wins.
  - tick in the same cycle as entering FILL: not counted (the load has priority).
  - bottle_edge outside MOVE: ignored.
- Counters never wrap. bottle_count is in 0..BATCH_SIZE-1 at all times.

Decomposition:
- Shared package holds the state encodings: IDLE=3'd0, MOVE=3'd1, FILL=3'd2, CAP=3'd3, ALARM=3'd4. Codes 5-7 are illegal and recover to IDLE on the next edge.
- One sub-module, sync_borda: 2-flop synchronizer plus rising-edge detector (ports clk, reset, din, edge_out). It is instantiated twice, for tick_src and bottle_sensor.

Test Plan:
Common setup: FILL_TICKS=5, CAP_TICKS=3, BATCH_SIZE=2; tick_src square wave, period 10 clk.
1. Reset asserted mid-FILL for 1 cycle -> next edge: state=0, valve=0, bottle_count=0; tick_src toggling during reset produces no tick afterwards until a new rising edge.
2. start=1, tank_low=0, then bottle_sensor rise -> motor=1 until FILL; valve=1 for exactly 5 ticks (about 50 clk); capper=1 for 3 ticks; bottle_count=1; state=MOVE.
3. Two complete bottles -> batch_done high for exactly 1 cycle at the end of the second CAP; bottle_count=0; state=IDLE.
4. tank_low=1 raised during FILL -> one edge later state=4, valve=0, alarm=1; start=1 with tank_low=0 -> state=0.
5. stop=1 and tank_low=1 in the same MOVE cycle -> state=0 (not ALARM); bottle_count unchanged.
6. bottle_sensor held high on entry to MOVE -> stays in MOVE; a low-then-high toggle -> FILL 2-3 cycles after the rise.
